// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file and trap unit.
package csr_pkg;

    localparam int XLEN = 32;

    // Implemented CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Interrupt cause codes
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    // funct3 encodings
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // Bit positions inside mstatus / mie / mip
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    // Outcome of the per-cycle trap/MRET priority decision
    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_TRAP = 2'd1,
        ACT_MRET = 2'd2
    } csr_act_e;

endpackage

// File: rtl/intr_sync.sv
// Two-flop synchronizer for an asynchronous level input.
module intr_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/csr_reg_file.sv
// Machine-mode CSR register file with timer/external interrupt entry and MRET.
module csr_reg_file
    import csr_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [XLEN_P-1:0] inst,
    input  logic [XLEN_P-1:0] pc,
    input  logic [XLEN_P-1:0] wdata,
    input  logic              csr_rd,
    input  logic              csr_wr,
    input  logic              is_mret,
    input  logic              timer_intr,
    input  logic              ext_intr,
    output logic [XLEN_P-1:0] rdata,
    output logic              epc_taken,
    output logic [XLEN_P-1:0] epc
);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mie_meie_q, mie_meie_d;
    logic        mip_mtip_q, mip_mtip_d;
    logic        mip_meip_q, mip_meip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic        ext_sync;
    logic [11:0] csr_addr;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [31:0] mstatus_val, mie_val, mip_val, old_val, src_val, new_val, pend;
    logic [3:0]  code;
    logic        irq, wr_en;
    csr_act_e    act;
    logic        unused_bits;

    assign csr_addr    = inst[31:20];
    assign funct3      = inst[14:12];
    assign rs1         = inst[19:15];
    assign unused_bits = ^{inst[11:0], pc[1:0]};

    intr_sync u_ext_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (ext_intr),
        .sync_o  (ext_sync)
    );

    // Architectural views of the CSRs and the old-value read mux
    always_comb begin
        mstatus_val               = '0;
        mstatus_val[MSTATUS_MIE]  = mstatus_mie_q;
        mstatus_val[MSTATUS_MPIE] = mstatus_mpie_q;
        mstatus_val[12:11]        = 2'b11;
        mie_val                   = '0;
        mie_val[MIE_MTIE]         = mie_mtie_q;
        mie_val[MIE_MEIE]         = mie_meie_q;
        mip_val                   = '0;
        mip_val[MIP_MTIP]         = mip_mtip_q;
        mip_val[MIP_MEIP]         = mip_meip_q;
        case (csr_addr)
            CSR_MSTATUS: old_val = mstatus_val;
            CSR_MIE:     old_val = mie_val;
            CSR_MTVEC:   old_val = mtvec_q;
            CSR_MEPC:    old_val = mepc_q;
            CSR_MCAUSE:  old_val = mcause_q;
            CSR_MIP:     old_val = mip_val;
            default:     old_val = '0;
        endcase
    end

    assign rdata = csr_rd ? old_val : '0;

    // Trap/MRET priority decision and redirect target
    always_comb begin
        pend = mie_val & mip_val;
        irq  = inst_valid & mstatus_mie_q & (|pend);
        code = pend[MIP_MEIP] ? CAUSE_MEI : CAUSE_MTI;
        act  = ACT_NONE;
        if (irq) begin
            act = ACT_TRAP;
        end else if (inst_valid && is_mret) begin
            act = ACT_MRET;
        end
        epc_taken = 1'b0;
        epc       = '0;
        if (!rst) begin
            case (act)
                ACT_TRAP: begin
                    epc_taken = 1'b1;
                    epc = {mtvec_q[31:2], 2'b00} + (mtvec_q[0] ? {26'b0, code, 2'b00} : 32'd0);
                end
                ACT_MRET: begin
                    epc_taken = 1'b1;
                    epc       = mepc_q;
                end
                default: ;
            endcase
        end
    end

    // Write-value computation for the CSRR* family
    always_comb begin
        src_val = funct3[2] ? {27'b0, rs1} : wdata;
        case (funct3[1:0])
            2'b01:   new_val = src_val;
            2'b10:   new_val = old_val | src_val;
            2'b11:   new_val = old_val & ~src_val;
            default: new_val = old_val;
        endcase
        // set/clear forms with a zero rs1 field are pure reads
        wr_en = inst_valid & csr_wr & (funct3[1:0] != 2'b00)
              & ~(funct3[1] & (rs1 == 5'd0)) & (act != ACT_TRAP);
    end

    // Next-state: trap entry beats MRET and CSR writes
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mip_mtip_d     = timer_intr;
        mip_meip_d     = ext_sync;
        if (act == ACT_TRAP) begin
            mepc_d         = {pc[31:2], 2'b00};
            mcause_d       = {1'b1, 27'b0, code};
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else begin
            if (wr_en) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie_d  = new_val[MSTATUS_MIE];
                        mstatus_mpie_d = new_val[MSTATUS_MPIE];
                    end
                    CSR_MIE: begin
                        mie_mtie_d = new_val[MIE_MTIE];
                        mie_meie_d = new_val[MIE_MEIE];
                    end
                    CSR_MTVEC:  mtvec_d  = {new_val[31:2], 1'b0, new_val[0]};
                    CSR_MEPC:   mepc_d   = {new_val[31:2], 2'b00};
                    CSR_MCAUSE: mcause_d = new_val;
                    default: ;
                endcase
            end
            if (act == ACT_MRET) begin
                mstatus_mie_d  = mstatus_mpie_q;
                mstatus_mpie_d = 1'b1;
            end
        end
    end

    // CSR state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mip_mtip_q     <= 1'b0;
            mip_meip_q     <= 1'b0;
            mtvec_q        <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mip_mtip_q     <= mip_mtip_d;
            mip_meip_q     <= mip_meip_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

endmodule
